// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one request at a time over req/gnt/rvalid and
// holds one returned instruction, with its PC+4, for the IF/ID register.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_addr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        valid_o
);

   typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

   state_e      state_q;
   logic        req_q;
   logic [31:0] pc_q;
   logic        buf_valid_q;
   logic [31:0] buf_inst_q;
   logic [31:0] buf_pc4_q;
   logic [31:0] slot_pc4_q;
   logic        kill_q;
   logic        pend_q;
   logic [31:0] pend_addr_q;

   logic [31:0] redir_addr;
   logic        consume;
   logic        show;

   assign redir_addr = redirect_addr_i & ~32'h3;
   assign consume    = buf_valid_q & ~stall_i & ~redirect_i;
   // A redirect hides the buffered instruction in the same cycle it is raised.
   assign show       = buf_valid_q & ~redirect_i;

   assign imem_req_o  = req_q;
   assign imem_addr_o = pc_q;
   assign valid_o     = show;
   assign inst_o      = show ? buf_inst_q : NOP_INST;
   assign inst_addr_o = show ? buf_pc4_q : 32'h0;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= StIdle;
         req_q       <= 1'b0;
         pc_q        <= RESET_PC;
         buf_valid_q <= 1'b0;
         buf_inst_q  <= NOP_INST;
         buf_pc4_q   <= 32'h0;
         slot_pc4_q  <= 32'h0;
         kill_q      <= 1'b0;
         pend_q      <= 1'b0;
         pend_addr_q <= 32'h0;
      end else begin
         if (consume || redirect_i) begin
            buf_valid_q <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (redirect_i) begin
                  pc_q <= redir_addr;
               end
               if (!buf_valid_q || consume) begin
                  state_q <= StReq;
                  req_q   <= 1'b1;
               end
            end
            StReq: begin
               if (imem_gnt_i) begin
                  state_q    <= StWait;
                  req_q      <= 1'b0;
                  slot_pc4_q <= pc_q + 32'd4;
                  pend_q     <= 1'b0;
                  // The request already in flight is wrong-path if any redirect touched it.
                  if (redirect_i) begin
                     kill_q <= 1'b1;
                     pc_q   <= redir_addr;
                  end else if (pend_q) begin
                     kill_q <= 1'b1;
                     pc_q   <= pend_addr_q;
                  end else begin
                     pc_q <= pc_q + 32'd4;
                  end
               end else if (redirect_i) begin
                  pend_q      <= 1'b1;
                  pend_addr_q <= redir_addr;
               end
            end
            StWait: begin
               if (redirect_i) begin
                  kill_q <= 1'b1;
                  pc_q   <= redir_addr;
               end
               if (imem_rvalid_i) begin
                  if (kill_q || redirect_i) begin
                     kill_q  <= 1'b0;
                     state_q <= StReq;
                     req_q   <= 1'b1;
                  end else begin
                     buf_valid_q <= 1'b1;
                     buf_inst_q  <= imem_rdata_i;
                     buf_pc4_q   <= slot_pc4_q;
                     state_q     <= StIdle;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule
